// File: rtl/mux_scan_sampler.sv
// Scans a downstream 4:1 key mux, holding each select SETTLE cycles before sampling into a 4-bit snapshot.
// Optional macro SCAN_CONT_EN: free-running back-to-back scans without start.
module mux_scan_sampler #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] mux_key,
  input  logic       mux_out,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [1:0] r_pos;
  logic [1:0] w_pos_next;
  logic [3:0] r_data;
  logic [3:0] w_data_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_pos   <= 2'd0;
      r_data  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pos   <= w_pos_next;
      r_data  <= w_data_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pos_next   = r_pos;
    w_data_next  = r_data;
    case (r_state)
      IDLE: begin
`ifdef SCAN_CONT_EN
        w_state_next = SCAN;
        w_pos_next   = 2'd0;
        w_cnt_next   = 4'd0;
`else
        if (start) begin
          w_state_next = SCAN;
          w_pos_next   = 2'd0;
          w_cnt_next   = 4'd0;
        end
`endif
      end
      SCAN: begin
        // Sample only after the select has been stable for SETTLE cycles.
        if (r_cnt == LP_LAST) begin
          w_data_next[r_pos] = mux_out;
          w_cnt_next         = 4'd0;
          if (r_pos == 2'd3) begin
            w_state_next = DONE;
            w_pos_next   = 2'd0;
          end else begin
            w_pos_next = r_pos + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      DONE: begin
        if (ready) begin
`ifdef SCAN_CONT_EN
          w_state_next = SCAN;
`else
          w_state_next = IDLE;
`endif
          w_pos_next = 2'd0;
          w_cnt_next = 4'd0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pos_next   = 2'd0;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  assign mux_key = r_pos;
  assign busy    = (r_state == SCAN);
  assign valid   = (r_state == DONE);
  assign data    = r_data;

endmodule

// File: doc/mux_scan_sampler.md
MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles each select value is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request one 4-position scan; sampled only in IDLE.
REQ-005 SHALL have port mux_key  output  2  select driven to the downstream 4:1 key mux.
REQ-006 SHALL have port mux_out  input  1  selected bit returned by the 4:1 key mux.
REQ-007 SHALL have port busy  output  1  high while in SCAN.
REQ-008 SHALL have port data  output  4  assembled snapshot; data[i] equals mux_out sampled while mux_key==i.
REQ-009 SHALL have port valid  output  1  data available; high only in DONE.
REQ-010 SHALL have port ready  input  1  consumer accepts data.

Function
REQ-011 SHALL implement states IDLE, SCAN, DONE, plus a 4-bit settle counter cnt and a 2-bit position register.
REQ-012 SHALL drive mux_key directly from the position register, never combinationally from inputs.
REQ-013 IDLE: mux_key=0, busy=0, valid=0, and data holds its last value; start=1 at an edge sets state=SCAN, position=0, cnt=0.
REQ-014 SCAN: busy=1; each edge with cnt<SETTLE-1 increments cnt.
REQ-015 SCAN: on the edge with cnt==SETTLE-1, data[position] SHALL load mux_out and cnt SHALL clear.
REQ-016 SCAN: that same edge SHALL increment position if position<3, else move to DONE with position=0.
REQ-017 Latency: start seen at edge t0 gives samples at edges t0+k*SETTLE (k=1..4), with valid=1 from edge t0+4*SETTLE.
REQ-018 Bits of data not yet resampled SHALL keep their previous value during SCAN; there is no clearing at scan start.
REQ-019 DONE: valid=1, busy=0, data stable; valid&&ready at an edge moves to IDLE (see REQ-025 for SCAN_CONT_EN).
REQ-020 DONE with ready=0 SHALL hold indefinitely with data and valid unchanged.
REQ-021 start SHALL be ignored in SCAN and DONE; no queuing.
REQ-022 ready SHALL be ignored outside DONE.
REQ-023 With SETTLE=1, SHALL sample every cycle, giving valid 4 cycles after start.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, position=0, cnt=0, data=4'b0000, mux_key=0, busy=0, valid=0, including mid-SCAN or mid-DONE with no partial result retained.

Configuration
REQ-025 Macro SCAN_CONT_EN defined: valid&&ready in DONE SHALL go directly to SCAN (position=0, cnt=0) with no IDLE cycle, and IDLE SHALL also leave on the first edge after reset without start, giving free-running scanning.
REQ-026 Macro SCAN_CONT_EN undefined: behaviour is exactly REQ-013..REQ-024, with scans only on start.

Verification
REQ-027 Bench: SETTLE=2, mux model value=4'b1010, start pulse at edge t0 -> mux_key 0,0,1,1,2,2,3,3; valid=1 from t0+8; data=4'b1010.
REQ-028 Bench: valid=1 with ready=0 for 5 cycles, value changed to 4'b0101 -> data stays 4'b1010; ready=1 -> IDLE next edge with valid=0.
REQ-029 Bench: start held high in SCAN and in DONE -> no restart; exactly one scan per IDLE entry (without SCAN_CONT_EN).
REQ-030 Bench: rst asserted asynchronously during SCAN at position 2 -> outputs zero without waiting for clk; a fresh start gives a correct full scan.
REQ-031 Bench: SETTLE=1, value=4'b0111 -> valid 4 cycles after start, data=4'b0111; SETTLE=15 -> valid 60 cycles after start.
REQ-032 Bench: SCAN_CONT_EN, ready tied 1 -> back-to-back scans with period 4*SETTLE+1 cycles and no start needed.
